ddr_init_engine: RTL
====================

DDR_INIT_ENGINE -- requirements
Module: ddr_init_engine

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- DATA_W, 256, Avalon data width in bits; multiple of 8.
- ADDR_W, 25, Avalon word address width.
- BURST_LEN, 64, maximum beats per burst; 1..127.
- WORDS, 2**ADDR_W, words to initialise, starting at word address 0.
- VERIFY, 1, enables the read-back verify pass.
REQ-002 The block SHALL use one clock and a synchronous, active-high reset; all ports are in the avalon_clk domain.
REQ-003 Ports, one per line: name, direction, width, meaning.
- avalon_clk  in  1  clock
- avalon_reset  in  1  synchronous active-high reset
- local_cal_success  in  1  EMIF calibration passed
- local_cal_fail  in  1  EMIF calibration failed
- start  in  1  one-cycle pulse; begins a run
- mode  in  2  0 = zero fill, 1 = constant, 2 = address pattern, 3 = reserved (treated as 0)
- pattern  in  32  constant for mode 1, replicated across DATA_W
- amm_addr  out  ADDR_W  word address
- amm_writedata  out  DATA_W  write data
- amm_readdata  in  DATA_W  read data
- amm_read / amm_write  out  1  command strobes
- amm_byteenable  out  DATA_W/8  byte enables; always all ones
- amm_burstcount  out  7  beats in the burst
- amm_ready  in  1  high = command/beat accepted (inverse of waitrequest)
- amm_readdatavalid  in  1  read beat valid
- busy  out  1  run in progress
- setup_done  out  1  sticky; run completed
- setup_error  out  1  sticky; calibration fail or verify mismatch
- err_count  out  16  count of mismatching words; saturates at 0xFFFF

Function
REQ-004 FSM states SHALL be IDLE, WAIT_CAL, WR_BURST, RD_CMD, RD_DATA, DONE, FAIL.
REQ-005 IDLE: a start pulse SHALL latch mode and pattern, clear setup_done, setup_error and err_count, and move to WAIT_CAL; start in any other state SHALL be ignored.
REQ-006 WAIT_CAL: local_cal_fail SHALL move to FAIL, even if asserted in the same cycle as local_cal_success; local_cal_success alone SHALL move to WR_BURST at address 0.
REQ-007 Burst length SHALL be min(BURST_LEN, remaining words), so the last burst of a non-multiple WORDS is short.
REQ-008 amm_addr and amm_burstcount SHALL hold constant for the whole burst.
REQ-009 WR_BURST: amm_write and amm_writedata SHALL hold until amm_ready is sampled high; the beat counter SHALL advance only on amm_write && amm_ready.
REQ-010 Write data SHALL be:
- mode 0: zero;
- mode 1: pattern replicated DATA_W/32 times;
- mode 2: current word address (base + beat index), zero-extended.
REQ-011 After the last write beat: with VERIFY = 1, go to RD_CMD at address 0; with VERIFY = 0, go to DONE.
REQ-012 RD_CMD SHALL assert amm_read for exactly one accepted cycle per burst, then move to RD_DATA; only one read burst SHALL be outstanding.
REQ-013 RD_DATA SHALL compare each amm_readdatavalid beat with the expected word; each mismatch SHALL increment err_count (saturating) and set setup_error.
REQ-014 After the burst's final beat, RD_DATA SHALL go to RD_CMD, or to DONE after the last burst.
REQ-015 DONE SHALL assert setup_done; setup_error SHALL retain any verify result.
REQ-016 FAIL SHALL assert setup_error and keep setup_done low.
REQ-017 A start pulse in DONE or FAIL SHALL re-run as from IDLE.
REQ-018 busy SHALL be high in WAIT_CAL, WR_BURST, RD_CMD and RD_DATA.
REQ-019 amm_read and amm_write SHALL never be high in the same cycle.
REQ-020 Address arithmetic SHALL be ADDR_W wide; WORDS = 2**ADDR_W SHALL end cleanly with no wrap-around rewrite of address 0.

Reset
REQ-021 On avalon_reset sampled high, at the next edge:
- state = IDLE;
- amm_read, amm_write, busy, setup_done, setup_error = 0;
- err_count, amm_addr, amm_burstcount, amm_writedata = 0;
- any burst in progress SHALL be abandoned, including one reset mid-operation.
REQ-022 Read beats arriving after reset SHALL be ignored.

Verification
REQ-023 WORDS=10, BURST_LEN=4, mode 2, slave always ready -> write bursts of 4/4/2 at addresses 0/4/8, data = address; verify passes; setup_done=1, err_count=0.
REQ-024 mode 1, pattern=0xA5A5_0F0F, amm_ready low for 3 cycles at beat 2 -> amm_writedata and amm_addr stable during the stall; no beat lost or duplicated.
REQ-025 local_cal_success and local_cal_fail high together -> FAIL; setup_error=1, setup_done=0, no Avalon traffic.
REQ-026 Slave corrupts words 3 and 7 on read -> err_count=2, setup_error=1, setup_done=1.
REQ-027 avalon_reset asserted during the second write burst -> amm_write=0 at the next edge; a new start reruns from address 0.
REQ-028 VERIFY=0, WORDS=5, BURST_LEN=8 -> single write burst, burstcount=5, amm_read never asserted.

Source files
------------

// File: rtl/ddr_init_engine.sv
// Post-calibration DDR initialiser: fills memory through Avalon-MM bursts with a
// selectable pattern, then optionally reads it back and counts mismatching words.
module ddr_init_engine #(
    parameter int unsigned DATA_W    = 256,
    parameter int unsigned ADDR_W    = 25,
    parameter int unsigned BURST_LEN = 64,
    parameter int unsigned WORDS     = 2**ADDR_W,
    parameter bit          VERIFY    = 1'b1
) (
    input  logic                  avalon_clk,
    input  logic                  avalon_reset,
    input  logic                  local_cal_success,
    input  logic                  local_cal_fail,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic [31:0]           pattern,
    output logic [ADDR_W-1:0]     amm_addr,
    output logic [DATA_W-1:0]     amm_writedata,
    input  logic [DATA_W-1:0]     amm_readdata,
    output logic                  amm_read,
    output logic                  amm_write,
    output logic [DATA_W/8-1:0]   amm_byteenable,
    output logic [6:0]            amm_burstcount,
    input  logic                  amm_ready,
    input  logic                  amm_readdatavalid,
    output logic                  busy,
    output logic                  setup_done,
    output logic                  setup_error,
    output logic [15:0]           err_count
);

    localparam int unsigned CW = ADDR_W + 8;
    // One extra bit so a run covering the full address space can reach WORDS without wrapping to 0.
    localparam logic [ADDR_W:0] WORDS_L = (ADDR_W+1)'(WORDS);

    typedef enum logic [2:0] {IDLE, WAIT_CAL, WR_BURST, RD_CMD, RD_DATA, DONE, FAIL} state_t;

    state_t           state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [31:0]      pattern_q, pattern_d;
    logic [ADDR_W:0]  base_q, base_d;
    logic [6:0]       beat_q, beat_d, blen_q, blen_d;
    logic             done_q, done_d, error_q, error_d;
    logic [15:0]      err_q, err_d;

    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W:0]   next_base;
    logic              last_beat;
    logic [DATA_W-1:0] exp_word;

    function automatic logic [6:0] burst_len(input logic [ADDR_W:0] base);
        logic [CW-1:0] rem;
        rem = CW'(WORDS) - CW'(base);
        if (rem >= CW'(BURST_LEN))
            return 7'(BURST_LEN);
        return 7'(rem);
    endfunction

    function automatic logic [DATA_W-1:0] word_data(input logic [1:0] m, input logic [31:0] p,
                                                   input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] d;
        d = '0;
        case (m)
            2'd1: for (int unsigned i = 0; i < DATA_W/8; i++) d[8*i +: 8] = p[8*(i%4) +: 8];
            2'd2: d = DATA_W'(a);
            default: d = '0;
        endcase
        return d;
    endfunction

    assign cur_addr       = base_q[ADDR_W-1:0] + ADDR_W'(beat_q);
    assign next_base      = base_q + (ADDR_W+1)'(blen_q);
    assign last_beat      = (beat_q == blen_q - 7'd1);
    assign exp_word       = word_data(mode_q, pattern_q, cur_addr);
    assign amm_byteenable = '1;
    assign setup_done     = done_q;
    assign setup_error    = error_q;
    assign err_count      = err_q;

    always_comb begin
        state_d        = state_q;
        mode_d         = mode_q;
        pattern_d      = pattern_q;
        base_d         = base_q;
        beat_d         = beat_q;
        blen_d         = blen_q;
        done_d         = done_q;
        error_d        = error_q;
        err_d          = err_q;
        amm_read       = 1'b0;
        amm_write      = 1'b0;
        amm_addr       = '0;
        amm_burstcount = '0;
        amm_writedata  = '0;
        busy           = 1'b0;
        case (state_q)
            IDLE, DONE, FAIL: begin
                if (start) begin
                    mode_d    = mode;
                    pattern_d = pattern;
                    done_d    = 1'b0;
                    error_d   = 1'b0;
                    err_d     = '0;
                    state_d   = WAIT_CAL;
                end
            end
            WAIT_CAL: begin
                busy = 1'b1;
                if (local_cal_fail) begin
                    error_d = 1'b1;
                    state_d = FAIL;
                end else if (local_cal_success) begin
                    base_d  = '0;
                    beat_d  = '0;
                    blen_d  = burst_len('0);
                    state_d = WR_BURST;
                end
            end
            WR_BURST: begin
                busy           = 1'b1;
                amm_write      = 1'b1;
                amm_addr       = base_q[ADDR_W-1:0];
                amm_burstcount = blen_q;
                amm_writedata  = exp_word;
                if (amm_ready) begin
                    if (last_beat) begin
                        beat_d = '0;
                        if (next_base == WORDS_L) begin
                            if (VERIFY) begin
                                base_d  = '0;
                                blen_d  = burst_len('0);
                                state_d = RD_CMD;
                            end else begin
                                done_d  = 1'b1;
                                state_d = DONE;
                            end
                        end else begin
                            base_d = next_base;
                            blen_d = burst_len(next_base);
                        end
                    end else begin
                        beat_d = beat_q + 7'd1;
                    end
                end
            end
            RD_CMD: begin
                busy           = 1'b1;
                amm_read       = 1'b1;
                amm_addr       = base_q[ADDR_W-1:0];
                amm_burstcount = blen_q;
                if (amm_ready) begin
                    beat_d  = '0;
                    state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                busy = 1'b1;
                if (amm_readdatavalid) begin
                    if (amm_readdata != exp_word) begin
                        error_d = 1'b1;
                        if (err_q != 16'hFFFF)
                            err_d = err_q + 16'd1;
                    end
                    if (last_beat) begin
                        beat_d = '0;
                        if (next_base == WORDS_L) begin
                            done_d  = 1'b1;
                            state_d = DONE;
                        end else begin
                            base_d  = next_base;
                            blen_d  = burst_len(next_base);
                            state_d = RD_CMD;
                        end
                    end else begin
                        beat_d = beat_q + 7'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge avalon_clk) begin
        if (avalon_reset) begin
            state_q   <= IDLE;
            mode_q    <= '0;
            pattern_q <= '0;
            base_q    <= '0;
            beat_q    <= '0;
            blen_q    <= '0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            pattern_q <= pattern_d;
            base_q    <= base_d;
            beat_q    <= beat_d;
            blen_q    <= blen_d;
            done_q    <= done_d;
            error_q   <= error_d;
            err_q     <= err_d;
        end
    end

endmodule
